// File: rtl/fpu_pipe_ctrl.sv
// fpu_pipe_ctrl: valid/ready control spine for the FPU datapath.
// Tracks live slots and tags, and drives per-stage load enables and clears.
module fpu_pipe_ctrl #(
  parameter int STAGES = 3,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              flush,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_clr,
  output logic [CNT_W-1:0]  occupancy,
  output logic              busy
);

  typedef logic [TAG_W-1:0] tag_t;

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] adv, inc_v;
  tag_t [STAGES-1:0] tag_q, tag_d, inc_tag;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              accept, retire;

  // Ready chain: a slot moves if it is empty or anything above it can move.
  always_comb begin : p_adv
    logic run;
    run = out_ready;
    adv = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      run    = run | ~v_q[i];
      adv[i] = run;
    end
  end

  assign in_ready = adv[0] & ~flush;
  assign accept   = in_valid & in_ready;
  assign retire   = v_q[STAGES-1] & out_ready;

  // What would enter each stage on an advance.
  always_comb begin
    inc_v      = '0;
    inc_tag    = '0;
    inc_v[0]   = accept;
    inc_tag[0] = in_tag;
    for (int i = 1; i < STAGES; i++) begin
      inc_v[i]   = v_q[i-1];
      inc_tag[i] = tag_q[i-1];
    end
  end

  // Next slot state: load on advance, hold on stall, flush empties all.
  always_comb begin
    v_d   = v_q;
    tag_d = tag_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush) begin
        v_d[i]   = 1'b0;
        tag_d[i] = '0;
      end else if (adv[i]) begin
        v_d[i]   = inc_v[i];
        tag_d[i] = inc_v[i] ? inc_tag[i] : '0;
      end
    end
  end

  // Occupancy: +1 on accept only, -1 on retire only, 0 on flush.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept & ~retire) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (retire & ~accept) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  // Slot, tag and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q   <= '0;
      tag_q <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      tag_q <= tag_d;
      occ_q <= occ_d;
    end
  end

  assign stage_en  = reset ? (adv & ~{STAGES{flush}}) : '0;
  assign stage_clr = reset ? ({STAGES{flush}} | (adv & ~inc_v)) : '1;

  assign out_valid = v_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign occupancy = occ_q;
  assign busy      = |occ_q;

  // The counter must always equal the number of live slots.
  a_occ: assert property (@(posedge clk) disable iff (!reset)
    (occ_q == CNT_W'($countones(v_q))) && (occ_q <= CNT_W'(STAGES)));

endmodule
